block_emitter: RTL and testbench
================================

# block_emitter

Command-driven ASCII character-stream generator; one character per clock on an 8-bit bus, the transmit-side counterpart of the begin/end block checker. Upstream logic issues token commands (BEGIN, END, WORD, SPACE). The block serialises each token with a trailing space and tracks nesting depth. It reports whether the stream emitted so far is balanced as the checker would judge it.

## Interface
Parameters:
- `DEPTH_W`, default 8: width of nesting-depth counter.

Ports:
- `clk`  input  1  sole clock; all state on rising edge.
- `reset`  input  1  synchronous, active-high; clears all state on the next rising edge.
- `cmd_valid`  input  1  command present.
- `cmd`  input  2  00 BEGIN, 01 END, 10 WORD, 11 SPACE.
- `word_len`  input  4  WORD length in letters; 0 treated as 1; ignored for other commands.
- `upper`  input  1  1 = emit letters uppercase; latched at accept.
- `cmd_ready`  output  1  block can accept a command this cycle.
- `out`  output  8  current ASCII character; registered.
- `out_valid`  output  1  `out` carries a token character; registered.
- `depth`  output  DEPTH_W  current nesting depth; registered.
- `err`  output  1  sticky: END at depth 0, or BEGIN at maximum depth.
- `balanced`  output  1  `!err && depth == 0`; combinational from registers.

## Operation
- States: IDLE, EMIT. Registers: token type, char index `idx` (4 bits), last index `last`, case bit.
- Accept: `cmd_valid && cmd_ready` at a rising edge. Latch cmd, case and `last`. Set `idx = 0` and enter EMIT. The first character is presented after that edge.
- `cmd_ready = (state == IDLE) || (state == EMIT && idx == last)`. This gives back-to-back tokens with no gap.
- Token character sequences, each ending in 0x20:
  - BEGIN: "begin " (6 chars, `last` = 5).
  - END: "end " (4 chars, `last` = 3).
  - WORD, length L (L = max(`word_len`, 1)): letters 'a'+i for i = 0..L-1, then space (`last` = L). A word always starts with 'a', so it never spells begin or end.
  - SPACE: " " (1 char, `last` = 0).
- Case: when the latched case bit is 1, letters are emitted as 'A'..'Z' (subtract 0x20). The space character is unaffected.
- Per EMIT cycle: `out` = char[idx] and `out_valid` = 1. Then:
  - If `idx == last` and a new command is accepted: reload and stay in EMIT.
  - If `idx == last` with no new command: go to IDLE.
  - Otherwise: `idx` + 1.
- IDLE: `out` = 0x20, `out_valid` = 0. The checker sees idle as word separators.
- Depth is updated at accept, not at emission:
  - BEGIN: `depth` + 1. If `depth` is all-ones, `depth` holds and `err` is set.
  - END: if `depth` > 0, `depth` − 1. If `depth` == 0, `depth` stays 0 and `err` is set.
  - WORD and SPACE: no change.
- `err` is sticky until `reset`. While `err` is set, `depth` keeps updating normally but `balanced` stays 0.
- Commands are never dropped: while `cmd_ready` = 0, upstream holds `cmd_valid` and the command fields stable.

## Timing
- After reset: state IDLE, `out` = 0x20, `out_valid` = 0, `depth` = 0, `err` = 0, `balanced` = 1, `cmd_ready` = 1.
- Accept at edge t: the token occupies `out` during cycles t+1 .. t+1+`last`. `depth` and `err` reflect the command from cycle t+1.
- Latency from accept to first character: 1 cycle. Throughput: 1 character per cycle.
- Simultaneous final character and new accept: the final character is still presented that cycle, and the new token's first character follows in the next cycle.
- Reset mid-token aborts the token. At the next edge, `out` = 0x20 and `out_valid` = 0, and all counters and flags take their reset values. Commands presented in the same cycle as `reset` are ignored.
- `word_len` = 0 and `word_len` = 1 both produce "a " (2 chars).

## Test plan
- Reset, then BEGIN with `upper` = 0 -> `out` = 62 65 67 69 6E 20 in cycles 1–6, `out_valid` = 1 throughout. `depth` = 1 and `balanced` = 0 from cycle 1. `cmd_ready` = 1 only in cycle 6.
- BEGIN, WORD(3), END held back-to-back with `upper` = 1 -> "BEGIN ABC END " in 14 consecutive valid cycles with no gap. `depth` sequence 1,1,0. `balanced` = 1 after END is accepted.
- END from reset -> `err` = 1, `depth` = 0, `balanced` = 0. A following BEGIN then END leaves `balanced` = 0 until `reset`.
- `DEPTH_W` = 2: four BEGINs -> `depth` saturates at 3 and `err` = 1 after the fourth accept.
- WORD with `word_len` = 0, then SPACE -> `out` = 61 20 20 with `out_valid` = 1 for all three cycles, then IDLE (`out_valid` = 0, `out` = 20).
- Assert `reset` during the 3rd character of BEGIN -> the next cycle shows `out` = 20, `out_valid` = 0, `depth` = 0, `balanced` = 1, `cmd_ready` = 1.

Source files
------------

// File: rtl/block_emitter.sv
// Token-driven ASCII stream generator: serialises BEGIN/END/WORD/SPACE tokens one
// character per clock and tracks begin/end nesting depth with a sticky error flag.
//
// state | meaning
// IDLE  | no token in flight; out = space, out_valid = 0
// EMIT  | presenting char[idx] of the latched token; reloads on final char if a command waits
module block_emitter #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic [3:0]         word_len,
    input  logic               upper,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               balanced
);
    localparam logic [1:0] CMD_BEGIN = 2'b00;
    localparam logic [1:0] CMD_END   = 2'b01;
    localparam logic [1:0] CMD_WORD  = 2'b10;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             r_state;
    logic [1:0]         r_tok;
    logic [3:0]         r_idx;
    logic [3:0]         r_last;
    logic               r_upper;
    logic [7:0]         r_out;
    logic               r_out_valid;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;

    logic               w_accept;
    logic [3:0]         w_new_last;

    function automatic logic [7:0] char_of(input logic [1:0] tok, input logic [3:0] idx,
                                           input logic [3:0] last, input logic up);
        logic [7:0] c;
        c = CH_SPACE;
        case (tok)
            CMD_BEGIN: begin
                case (idx)
                    4'd0:    c = 8'h62;
                    4'd1:    c = 8'h65;
                    4'd2:    c = 8'h67;
                    4'd3:    c = 8'h69;
                    4'd4:    c = 8'h6E;
                    default: c = CH_SPACE;
                endcase
            end
            CMD_END: begin
                case (idx)
                    4'd0:    c = 8'h65;
                    4'd1:    c = 8'h6E;
                    4'd2:    c = 8'h64;
                    default: c = CH_SPACE;
                endcase
            end
            CMD_WORD: begin
                if (idx != last) c = 8'h61 + {4'b0000, idx};
            end
            default: c = CH_SPACE;
        endcase
        // only letters change case; the separator stays a space
        if (up && c != CH_SPACE) c = c - 8'h20;
        return c;
    endfunction

    assign cmd_ready = (r_state == IDLE) || (r_idx == r_last);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_new_last = 4'd0;
        case (cmd)
            CMD_BEGIN: w_new_last = 4'd5;
            CMD_END:   w_new_last = 4'd3;
            CMD_WORD:  w_new_last = (word_len == 4'd0) ? 4'd1 : word_len;
            default:   w_new_last = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tok       <= 2'b00;
            r_idx       <= 4'd0;
            r_last      <= 4'd0;
            r_upper     <= 1'b0;
            r_out       <= CH_SPACE;
            r_out_valid <= 1'b0;
            r_depth     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state     <= EMIT;
                r_tok       <= cmd;
                r_idx       <= 4'd0;
                r_last      <= w_new_last;
                r_upper     <= upper;
                r_out       <= char_of(cmd, 4'd0, w_new_last, upper);
                r_out_valid <= 1'b1;
                // depth tracks accepted commands, ahead of their characters
                if (cmd == CMD_BEGIN) begin
                    if (&r_depth) r_err <= 1'b1;
                    else          r_depth <= r_depth + DEPTH_W'(1);
                end else if (cmd == CMD_END) begin
                    if (r_depth == '0) r_err <= 1'b1;
                    else               r_depth <= r_depth - DEPTH_W'(1);
                end
            end else if (r_state == EMIT && r_idx != r_last) begin
                r_idx       <= r_idx + 4'd1;
                r_out       <= char_of(r_tok, r_idx + 4'd1, r_last, r_upper);
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= IDLE;
                r_out       <= CH_SPACE;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign depth     = r_depth;
    assign err       = r_err;
    assign balanced  = !r_err && (r_depth == '0);

endmodule

// File: tb/tb_block_emitter.sv
// Directed bench for block_emitter: a vector table for a back-to-back token run plus
// hand-written sequences for reset, error, saturation and short-token corners.
module tb_block_emitter;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] word_len;
    logic       upper;

    logic       cmd_ready, out_valid, err, balanced;
    logic [7:0] out;
    logic [7:0] depth;

    logic       cmd_ready2, out_valid2, err2, balanced2;
    logic [7:0] out2;
    logic [1:0] depth2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    block_emitter #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .word_len(word_len),
        .upper(upper), .cmd_ready(cmd_ready), .out(out), .out_valid(out_valid),
        .depth(depth), .err(err), .balanced(balanced)
    );

    block_emitter #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .word_len(word_len),
        .upper(upper), .cmd_ready(cmd_ready2), .out(out2), .out_valid(out_valid2),
        .depth(depth2), .err(err2), .balanced(balanced2)
    );

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [3:0] l;
        logic       u;
        logic [7:0] e_out;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_bal;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // holds the command until it is accepted, then drops cmd_valid
    task automatic send(input logic [1:0] c, input logic [3:0] l, input logic u);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1; cmd = c; word_len = l; upper = u;
        for (int n = 0; n < 40 && !done; n++) begin
            if (cmd_ready) done = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_timeout actual=0 required=1");
        end
    endtask

    initial begin
        logic [7:0] begin_lc [6];
        begin_lc[0] = 8'h62; begin_lc[1] = 8'h65; begin_lc[2] = 8'h67;
        begin_lc[3] = 8'h69; begin_lc[4] = 8'h6E; begin_lc[5] = 8'h20;

        // BEGIN, WORD(3), END uppercase, each held until accepted
        vecs[0]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h42, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h45, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h47, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h49, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h4E, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h20, 1'b1, 8'd1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 4'd3, 1'b1, 8'h41, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 4'd0, 1'b1, 8'h42, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 4'd0, 1'b1, 8'h43, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 4'd0, 1'b1, 8'h20, 1'b1, 8'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'd1, 4'd0, 1'b1, 8'h45, 1'b1, 8'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 8'h4E, 1'b1, 8'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 4'd0, 1'b0, 8'h44, 1'b1, 8'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 4'd0, 1'b0, 8'h20, 1'b1, 8'd0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 4'd0, 1'b0, 8'h20, 1'b0, 8'd0, 1'b1, 1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; word_len = 4'd0; upper = 1'b0;
        step(); step();
        reset = 1'b0;

        check("rst_out",      out, 8'h20);
        check("rst_valid",    {7'd0, out_valid}, 8'd0);
        check("rst_depth",    depth, 8'd0);
        check("rst_err",      {7'd0, err}, 8'd0);
        check("rst_balanced", {7'd0, balanced}, 8'd1);
        check("rst_ready",    {7'd0, cmd_ready}, 8'd1);

        // lowercase BEGIN: six characters, ready only on the trailing space
        cmd_valid = 1'b1; cmd = 2'd0; upper = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("begin_lc_out",   out, begin_lc[i]);
            check("begin_lc_valid", {7'd0, out_valid}, 8'd1);
            check("begin_lc_depth", depth, 8'd1);
            check("begin_lc_bal",   {7'd0, balanced}, 8'd0);
            check("begin_lc_ready", {7'd0, cmd_ready}, (i == 5) ? 8'd1 : 8'd0);
            step();
        end
        check("begin_lc_idle", {7'd0, out_valid}, 8'd0);

        // back-to-back uppercase stream from the vector table
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cmd_valid = vecs[i].v; cmd = vecs[i].c; word_len = vecs[i].l; upper = vecs[i].u;
            step();
            check($sformatf("vec%0d_out", i),   out, vecs[i].e_out);
            check($sformatf("vec%0d_valid", i), {7'd0, out_valid}, {7'd0, vecs[i].e_v});
            check($sformatf("vec%0d_depth", i), depth, vecs[i].e_d);
            check($sformatf("vec%0d_bal", i),   {7'd0, balanced}, {7'd0, vecs[i].e_bal});
            check($sformatf("vec%0d_ready", i), {7'd0, cmd_ready}, {7'd0, vecs[i].e_rdy});
        end

        // END at depth 0 is sticky
        do_reset();
        send(2'd1, 4'd0, 1'b0);
        check("underflow_err",   {7'd0, err}, 8'd1);
        check("underflow_depth", depth, 8'd0);
        check("underflow_bal",   {7'd0, balanced}, 8'd0);
        send(2'd0, 4'd0, 1'b0);
        check("sticky_depth1", depth, 8'd1);
        send(2'd1, 4'd0, 1'b0);
        check("sticky_depth0", depth, 8'd0);
        check("sticky_err",    {7'd0, err}, 8'd1);
        check("sticky_bal",    {7'd0, balanced}, 8'd0);

        // saturation on the 2-bit instance
        do_reset();
        send(2'd0, 4'd0, 1'b0);
        send(2'd0, 4'd0, 1'b0);
        send(2'd0, 4'd0, 1'b0);
        check("sat3_depth2", {6'd0, depth2}, 8'd3);
        check("sat3_err2",   {7'd0, err2}, 8'd0);
        send(2'd0, 4'd0, 1'b0);
        check("sat4_depth2", {6'd0, depth2}, 8'd3);
        check("sat4_err2",   {7'd0, err2}, 8'd1);
        check("sat4_depth8", depth, 8'd4);
        check("sat4_err8",   {7'd0, err}, 8'd0);

        // WORD with length 0, then SPACE
        do_reset();
        send(2'd2, 4'd0, 1'b0);
        check("w0_char_a",  out, 8'h61);
        check("w0_valid_a", {7'd0, out_valid}, 8'd1);
        cmd_valid = 1'b1; cmd = 2'd3; word_len = 4'd0; upper = 1'b0;
        step();
        check("w0_char_sp",  out, 8'h20);
        check("w0_valid_sp", {7'd0, out_valid}, 8'd1);
        check("w0_ready_sp", {7'd0, cmd_ready}, 8'd1);
        step();
        cmd_valid = 1'b0;
        check("space_char",  out, 8'h20);
        check("space_valid", {7'd0, out_valid}, 8'd1);
        step();
        check("space_idle_valid", {7'd0, out_valid}, 8'd0);
        check("space_idle_out",   out, 8'h20);

        // reset during the third character of BEGIN; concurrent END is ignored
        do_reset();
        send(2'd0, 4'd0, 1'b0);
        step(); step();
        check("abort_pre_out", out, 8'h67);
        reset = 1'b1; cmd_valid = 1'b1; cmd = 2'd1;
        step();
        reset = 1'b0; cmd_valid = 1'b0;
        check("abort_out",   out, 8'h20);
        check("abort_valid", {7'd0, out_valid}, 8'd0);
        check("abort_depth", depth, 8'd0);
        check("abort_bal",   {7'd0, balanced}, 8'd1);
        check("abort_ready", {7'd0, cmd_ready}, 8'd1);
        check("abort_err",   {7'd0, err}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
